// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the A-side memory port arbiter: FSM states, requester ids
// and the idle write mask.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam logic [3:0] WMASK_NONE = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_prio_starve_arb.sv
// Two-input priority arbiter: data wins by default, fetch is forced through
// once it has lost STARVE_MAX consecutive arbitration cycles.
module prio_starve_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic req_if,
    input  logic req_d,
    output logic gnt_if,
    output logic gnt_d
);

    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        gnt_d  = arb_en && req_d && !(req_if && starved);
        gnt_if = arb_en && req_if && !gnt_d;
    end

    // Any arbitration cycle that is not a fetch loss restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (req_if && gnt_d) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the A-side memory port between instruction fetch and load/store,
// one transaction outstanding, all bus-side outputs registered.
//
// state  | meaning
// IDLE   | no transaction, arbitrating
// ACCESS | bus driven, latency counter runs 0..MEM_LAT
// RESP   | rvalid pulse to the winner, arbitrating for the next transaction
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wmask,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);

    state_t     state;
    req_id_t    owner;
    logic       we_q;
    logic [2:0] lat_cnt;
    logic       arb_en;
    logic       gnt_if;
    logic       gnt_d;

    // Grants are suppressed while reset is held so every output reads 0.
    assign arb_en = rst && ((state == IDLE) || (state == RESP));
    assign if_gnt = gnt_if;
    assign d_gnt  = gnt_d;
    assign busy   = (state == ACCESS);

    prio_starve_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
        .req_if (if_req),
        .req_d  (d_req),
        .gnt_if (gnt_if),
        .gnt_d  (gnt_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= REQ_IF;
            we_q      <= 1'b0;
            lat_cnt   <= '0;
            bus_addr  <= '0;
            bus_wmask <= WMASK_NONE;
            bus_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (gnt_d) begin
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        bus_wmask <= d_we ? d_wmask : WMASK_NONE;
                        owner     <= REQ_D;
                        we_q      <= d_we;
                        lat_cnt   <= '0;
                        state     <= ACCESS;
                    end else if (gnt_if) begin
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                        bus_wmask <= WMASK_NONE;
                        owner     <= REQ_IF;
                        we_q      <= 1'b0;
                        lat_cnt   <= '0;
                        state     <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (lat_cnt == 3'(MEM_LAT)) begin
                        // Dropping the mask here keeps each store to a single write burst.
                        bus_wmask <= WMASK_NONE;
                        state     <= RESP;
                        if (owner == REQ_D) begin
                            d_rdata  <= we_q ? '0 : bus_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= bus_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single A-side memory port (ROM/RAM address map) between the instruction-fetch requester and the load/store data requester.
- Each requester uses a req/gnt handshake and receives a one-cycle rvalid response.
- Only one transaction is outstanding at a time.
- All bus-side outputs are registered; the block sits between the core pipeline and the memory bus controller.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from bus address valid to bus_rdata valid (synchronous block RAM = 1); legal range 1..4.
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wmask  in  4  byte write enables, used only when d_we=1.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid or store acknowledge, one-cycle pulse.
- d_rdata  out  DATA_W  load data; 0 for stores.
- bus_addr  out  ADDR_W  registered address to bus controller.
- bus_wmask  out  4  registered byte write mask; 0 unless a store is active.
- bus_wdata  out  DATA_W  registered write data.
- bus_rdata  in  DATA_W  read data from bus controller.
- busy  out  1  transaction in flight (state != IDLE and != RESP).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; starvation count=0.
  - All outputs are 0, including bus_addr=0 (ROM region, harmless) and bus_wmask=0.
  - A transaction in flight when reset asserts is dropped; no rvalid is emitted after reset releases.
- FSM states:
  - IDLE: no transaction.
  - ACCESS: bus driven, latency counter runs 0..MEM_LAT.
  - RESP: rvalid pulse.
- Arbitration happens only in IDLE or RESP, so back-to-back transactions are possible.
- Winner selection:
  - d_req wins over if_req, unless starvation count == STARVE_MAX, in which case fetch wins.
  - A lone requester always wins.
- gnt is combinational in the arbitration cycle T; exactly one of if_gnt/d_gnt may be high.
- At the edge ending T:
  - The winner's addr, wmask and wdata are latched into the bus_* registers.
  - The requester id and the we flag are latched.
  - State goes to ACCESS with counter = 0.
  - bus_wmask = d_wmask only when the data port won with d_we=1; otherwise 0.
- ACCESS:
  - bus_* are held stable for MEM_LAT+1 cycles (T+1 .. T+1+MEM_LAT).
  - At the edge ending cycle T+1+MEM_LAT, bus_rdata is captured into the winner's rdata register (stores capture 0).
  - bus_wmask is cleared to 0 and bus_addr is held.
  - State goes to RESP.
- RESP (cycle T+2+MEM_LAT):
  - The winner's rvalid=1 for exactly one cycle.
  - rdata holds its value until the next capture for that port.
  - With MEM_LAT=1: gnt at T, rvalid at T+3.
  - A new grant may occur in the RESP cycle. Otherwise the next state is IDLE.
- A store writes exactly once: bus_wmask is nonzero only during the ACCESS cycles of that store.
- Starvation count:
  - Increments (saturating at STARVE_MAX) in each arbitration cycle where if_req=1 and data wins.
  - Cleared when fetch wins or when if_req=0 in an arbitration cycle.
- Requester rules:
  - req and its fields must stay stable until gnt.
  - After gnt they may change or deassert without effect on the active transaction.
  - A requester must not expect a gnt while busy.
- Addresses and masks pass through unmodified. Alignment and mask generation are the requester's responsibility. Address decode stays in the bus controller.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum state_t {IDLE, ACCESS, RESP};
  - typedef enum req_id_t {REQ_IF, REQ_D};
  - constant WMASK_NONE = 4'b0000.
- One natural sub-module is prio_starve_arb: the two-input priority arbiter plus saturating starvation counter, with outputs gnt_if and gnt_d.
- The FSM and bus registers stay in the top module.

Test Plan:
- Reset: drive rst=0 mid-ACCESS of a store with wmask=4'hF.
  - All outputs go to 0 immediately.
  - After release, no rvalid appears and bus_wmask stays 0.
- Single fetch: if_req=1, if_addr=0x0000_0010, ROM word 0x0000_0013.
  - if_gnt at T; bus_addr=0x10 at T+1..T+2.
  - if_rvalid=1 and if_rdata=0x0000_0013 at T+3 only.
- Store then load: d_we=1, d_addr=0x1000_0004, d_wmask=4'h3, d_wdata=0xDEAD_BEEF; then a load from the same address.
  - bus_wmask=4'h3 for exactly 2 cycles; d_rvalid ack with d_rdata=0.
  - The load returns 0x0000_BEEF (prior contents 0).
- Contention: if_req and d_req held high continuously, STARVE_MAX=4.
  - Grant order is D,D,D,D,IF,D,D,D,D,IF.
  - Grants are never simultaneous.
- Back-to-back: d_req high with a new address in the RESP cycle.
  - d_gnt in the same cycle as d_rvalid; no idle cycle between transactions.
- Request withdrawn: if_req pulsed for one cycle while busy.
  - No if_gnt; the starvation count is cleared at the next arbitration cycle.
